// File: rtl/fft_magnitude.sv
// Streaming complex-to-magnitude stage: floor(sqrt(re^2 + im^2)) per FFT bin,
// fully pipelined, with bin-index sequence checking and a completed-frame counter.
module fft_magnitude #(
    parameter int FFT_WIDTH  = 16,
    parameter int FFT_POINTS = 1024,
    parameter int MAG_WIDTH  = 24,
    localparam int IW = $clog2(FFT_POINTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [FFT_WIDTH-1:0] fft_re,
    input  logic signed [FFT_WIDTH-1:0] fft_im,
    input  logic                        fft_valid,
    input  logic                        fft_last,
    input  logic [IW-1:0]               fft_index,
    output logic [MAG_WIDTH-1:0]        magnitude_out,
    output logic                        magnitude_valid,
    output logic                        magnitude_last,
    output logic [IW-1:0]               magnitude_index,
    output logic                        index_error,
    output logic [15:0]                 frame_count
);

    localparam int W  = FFT_WIDTH;
    localparam int L  = W + 2;
    localparam int SW = 2 * W + 1;
    localparam int RW = W + 3;

    logic signed [2*W-1:0] re_ext, im_ext;
    logic signed [2*W-1:0] re_sq, im_sq;
    logic [SW-1:0]         sum_q;
    logic [L-1:0]          vld_pipe, last_pipe;
    logic [IW-1:0]         idx_pipe [L];
    logic [IW-1:0]         expected;

    assign re_ext = (2*W)'(fft_re);
    assign im_ext = (2*W)'(fft_im);

    // Data path registers carry no reset; only the valid bits decide what is real.
    always_ff @(posedge clk) begin
        re_sq <= re_ext * re_ext;
        im_sq <= im_ext * im_ext;
        sum_q <= {1'b0, re_sq} + {1'b0, im_sq};
    end

    // Restoring square root, one root bit per stage, two radicand bits consumed per stage.
    for (genvar s = 0; s < W; s++) begin : g_sqrt
        logic [RW-1:0]  rem_in, rem_sh, trial;
        logic [W-1:0]   root_in, root_q;
        logic [2*W-1:0] rad_in;
        logic           take;

        if (s == 0) begin : g_first
            assign rem_in  = RW'(sum_q >> (2 * W));
            assign root_in = '0;
            assign rad_in  = sum_q[2*W-1:0];
        end else begin : g_next
            assign rem_in  = g_sqrt[s-1].g_carry.rem_q;
            assign root_in = g_sqrt[s-1].root_q;
            assign rad_in  = g_sqrt[s-1].g_carry.rad_q;
        end

        assign rem_sh = (rem_in << 2) | RW'(rad_in >> (2 * W - 2));
        assign trial  = {1'b0, root_in, 2'b01};
        assign take   = (rem_sh >= trial);

        always_ff @(posedge clk) begin
            root_q <= take ? ((root_in << 1) | W'(1)) : (root_in << 1);
        end

        if (s < W - 1) begin : g_carry
            logic [RW-1:0]  rem_q;
            logic [2*W-1:0] rad_q;
            always_ff @(posedge clk) begin
                rem_q <= take ? (rem_sh - trial) : rem_sh;
                rad_q <= rad_in << 2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[L-2:0], fft_valid};
            last_pipe <= {last_pipe[L-2:0], fft_valid & fft_last};
        end
    end

    always_ff @(posedge clk) begin
        idx_pipe[0] <= fft_index;
        for (int i = 1; i < L; i++) begin
            idx_pipe[i] <= idx_pipe[i-1];
        end
    end

    // Output register forces the magnitude to zero on idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            magnitude_out   <= '0;
            magnitude_valid <= 1'b0;
            magnitude_last  <= 1'b0;
            magnitude_index <= '0;
        end else begin
            magnitude_out   <= vld_pipe[L-1] ? MAG_WIDTH'(g_sqrt[W-1].root_q) : '0;
            magnitude_valid <= vld_pipe[L-1];
            magnitude_last  <= last_pipe[L-1];
            magnitude_index <= vld_pipe[L-1] ? idx_pipe[L-1] : '0;
        end
    end

    // A mismatch resynchronises to the received index; a last beat restarts at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            expected    <= '0;
            index_error <= 1'b0;
        end else if (fft_valid) begin
            index_error <= (fft_index != expected);
            expected    <= fft_last ? '0 : fft_index + IW'(1);
        end else begin
            index_error <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count <= '0;
        end else if (magnitude_valid && magnitude_last) begin
            frame_count <= frame_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_fft_magnitude.sv
// Directed-vector bench for fft_magnitude: corner magnitudes, latency, frames,
// index checking, bubbles and mid-stream reset.
module tb_fft_magnitude;

    localparam int W  = 16;
    localparam int P  = 1024;
    localparam int M  = 24;
    localparam int IW = 10;
    localparam int L  = W + 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic signed [W-1:0] fft_re = '0;
    logic signed [W-1:0] fft_im = '0;
    logic                fft_valid = 1'b0;
    logic                fft_last = 1'b0;
    logic [IW-1:0]       fft_index = '0;
    logic [M-1:0]        magnitude_out;
    logic                magnitude_valid;
    logic                magnitude_last;
    logic [IW-1:0]       magnitude_index;
    logic                index_error;
    logic [15:0]         frame_count;

    typedef struct {
        int           cyc;
        logic [M-1:0] mag;
        logic [IW-1:0] idx;
        logic         last;
    } beat_t;

    beat_t out_q[$];
    int    err_q[$];
    int    cyc = 0;
    int    stale_cnt = 0;
    int    vectors = 0;
    int    miscompares = 0;
    int    next_idx = 0;

    fft_magnitude #(.FFT_WIDTH(W), .FFT_POINTS(P), .MAG_WIDTH(M)) dut (
        .clk(clk), .rst(rst),
        .fft_re(fft_re), .fft_im(fft_im), .fft_valid(fft_valid),
        .fft_last(fft_last), .fft_index(fft_index),
        .magnitude_out(magnitude_out), .magnitude_valid(magnitude_valid),
        .magnitude_last(magnitude_last), .magnitude_index(magnitude_index),
        .index_error(index_error), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every output beat and error pulse, tagged with the edge that produced it.
    always @(negedge clk) begin
        if (magnitude_valid === 1'b1) begin
            out_q.push_back('{cyc, magnitude_out, magnitude_index, magnitude_last});
        end else if (magnitude_out !== '0) begin
            stale_cnt++;
        end
        if (index_error === 1'b1) err_q.push_back(cyc);
    end

    function automatic longint isqrt(input longint n);
        longint lo = 0, hi = 65536, mid;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= n) lo = mid;
            else hi = mid - 1;
        end
        return lo;
    endfunction

    task automatic drive(input bit v, input int re, input int im, input int idx,
                         input bit last, output int edge_n);
        @(negedge clk);
        fft_valid = v;
        fft_re    = W'(re);
        fft_im    = W'(im);
        fft_index = IW'(idx);
        fft_last  = last;
        edge_n    = cyc + 1;
    endtask

    task automatic idle(input int n);
        int e;
        repeat (n) drive(1'b0, 0, 0, 0, 1'b0, e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        fft_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        next_idx = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({magnitude_valid, magnitude_last, index_error} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags got %b want 000", {magnitude_valid, magnitude_last, index_error});
        end
        vectors++;
        if (magnitude_out !== '0 || magnitude_index !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_data got mag=%0d idx=%0d want 0/0", magnitude_out, magnitude_index);
        end
        vectors++;
        if (frame_count !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_frames got %0d want 0", frame_count);
        end
    endtask

    task automatic test_full_frame();
        int e0, e, bad_cyc, bad_mag, bad_idx, bad_last, first_bad;
        longint re, im;
        out_q.delete();
        err_q.delete();
        for (int i = 0; i < P; i++) begin
            drive(1'b1, i * 31 - 16000, 7 * i - 3000, i, i == P - 1, e);
            if (i == 0) e0 = e;
        end
        idle(L + 6);
        vectors++;
        if (out_q.size() != P) begin
            miscompares++;
            $display("[TB] FAIL frame_count_beats got %0d want %0d", out_q.size(), P);
        end
        bad_cyc = 0; bad_mag = 0; bad_idx = 0; bad_last = 0; first_bad = -1;
        foreach (out_q[j]) begin
            re = j * 31 - 16000;
            im = 7 * j - 3000;
            if (out_q[j].cyc != e0 + L + j) bad_cyc++;
            if (out_q[j].mag !== M'(isqrt(re * re + im * im))) begin
                bad_mag++;
                if (first_bad < 0) first_bad = j;
            end
            if (out_q[j].idx !== IW'(j)) bad_idx++;
            if (out_q[j].last !== (j == P - 1)) bad_last++;
        end
        vectors++;
        if (bad_cyc != 0) begin
            miscompares++;
            $display("[TB] FAIL frame_timing got %0d late/early beats want 0", bad_cyc);
        end
        vectors++;
        if (bad_mag != 0) begin
            miscompares++;
            $display("[TB] FAIL frame_mag got %0d wrong magnitudes (first at %0d) want 0", bad_mag, first_bad);
        end
        vectors++;
        if (bad_idx != 0 || bad_last != 0) begin
            miscompares++;
            $display("[TB] FAIL frame_idx_last got idx_err=%0d last_err=%0d want 0/0", bad_idx, bad_last);
        end
        vectors++;
        if (frame_count !== 16'd1 || err_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL frame_one got frames=%0d errs=%0d want 1/0", frame_count, err_q.size());
        end
        out_q.delete();
        for (int i = 0; i < P; i++) drive(1'b1, i, -i, i, i == P - 1, e);
        idle(L + 6);
        vectors++;
        if (frame_count !== 16'd2 || out_q.size() != P) begin
            miscompares++;
            $display("[TB] FAIL frame_two got frames=%0d beats=%0d want 2/%0d", frame_count, out_q.size(), P);
        end
        next_idx = 0;
    endtask

    task automatic test_single();
        int e;
        out_q.delete();
        drive(1'b1, 3, 4, 0, 1'b0, e);
        idle(L + 6);
        next_idx = 1;
        vectors++;
        if (out_q.size() != 1) begin
            miscompares++;
            $display("[TB] FAIL single_beats got %0d want 1", out_q.size());
        end else begin
            vectors++;
            if (out_q[0].cyc != e + L || out_q[0].mag !== M'(5) || out_q[0].idx !== '0) begin
                miscompares++;
                $display("[TB] FAIL single_beat got cyc=%0d mag=%0d idx=%0d want cyc=%0d mag=5 idx=0",
                         out_q[0].cyc, out_q[0].mag, out_q[0].idx, e + L);
            end
        end
    endtask

    task automatic test_corners();
        int re_v[8]  = '{-32768, 0, 1, -32768, 32767, 5, -7, 1};
        int im_v[8]  = '{-32768, 0, 1, 0, 32767, 12, 24, 2};
        int mag_v[8] = '{46340, 0, 1, 32768, 46339, 13, 25, 2};
        int e, e0;
        out_q.delete();
        err_q.delete();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, re_v[i], im_v[i], next_idx, 1'b0, e);
            next_idx++;
            if (i == 0) e0 = e;
        end
        idle(L + 6);
        vectors++;
        if (out_q.size() != 8 || err_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL corner_count got beats=%0d errs=%0d want 8/0", out_q.size(), err_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (out_q[i].mag !== M'(mag_v[i]) || out_q[i].cyc != e0 + L + i) begin
                    miscompares++;
                    $display("[TB] FAIL corner_%0d got mag=%0d cyc=%0d want mag=%0d cyc=%0d",
                             i, out_q[i].mag, out_q[i].cyc, mag_v[i], e0 + L + i);
                end
            end
        end
    endtask

    task automatic test_index_error();
        int idx_v[5] = '{0, 1, 2, 5, 6};
        int e, e5;
        do_reset();
        out_q.delete();
        err_q.delete();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, idx_v[i] + 1, 0, idx_v[i], 1'b0, e);
            if (i == 3) e5 = e;
        end
        next_idx = 7;
        idle(L + 6);
        vectors++;
        if (err_q.size() != 1) begin
            miscompares++;
            $display("[TB] FAIL idx_err_count got %0d pulses want 1", err_q.size());
        end else begin
            vectors++;
            if (err_q[0] != e5) begin
                miscompares++;
                $display("[TB] FAIL idx_err_cycle got %0d want %0d", err_q[0], e5);
            end
        end
        vectors++;
        if (out_q.size() != 5) begin
            miscompares++;
            $display("[TB] FAIL idx_err_beats got %0d want 5", out_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (out_q[i].mag !== M'(idx_v[i] + 1) || out_q[i].idx !== IW'(idx_v[i])) begin
                    miscompares++;
                    $display("[TB] FAIL idx_err_beat_%0d got mag=%0d idx=%0d want %0d/%0d",
                             i, out_q[i].mag, out_q[i].idx, idx_v[i] + 1, idx_v[i]);
                end
            end
        end
    endtask

    task automatic test_gaps();
        bit pat[12] = '{1, 0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 1};
        int exp_cyc[$];
        int exp_mag[$];
        int e, bad;
        out_q.delete();
        err_q.delete();
        for (int i = 0; i < 12; i++) begin
            if (pat[i]) begin
                drive(1'b1, 100 + i, 0, next_idx, 1'b0, e);
                exp_cyc.push_back(e + L);
                exp_mag.push_back(100 + i);
                next_idx++;
            end else begin
                drive(1'b0, 999, 999, int'($urandom_range(0, P - 1)), 1'b1, e);
            end
        end
        idle(L + 6);
        vectors++;
        if (out_q.size() != exp_cyc.size() || err_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL gaps_count got beats=%0d errs=%0d want %0d/0",
                     out_q.size(), err_q.size(), exp_cyc.size());
        end else begin
            bad = 0;
            foreach (out_q[j])
                if (out_q[j].cyc != exp_cyc[j] || out_q[j].mag !== M'(exp_mag[j])) bad++;
            vectors++;
            if (bad != 0) begin
                miscompares++;
                $display("[TB] FAIL gaps_pattern got %0d misplaced beats want 0", bad);
            end
        end
    endtask

    task automatic test_reset_midflight();
        int e;
        drive(1'b1, 6, 8, next_idx, 1'b1, e);
        idle(L + 4);
        vectors++;
        if (frame_count !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL midrst_pre_frames got %0d want 1", frame_count);
        end
        out_q.delete();
        for (int i = 0; i < 10; i++) drive(1'b1, 300 + i, 0, i, 1'b0, e);
        do_reset();
        vectors++;
        if ({magnitude_valid, magnitude_last, index_error} !== 3'b000 || magnitude_out !== '0 ||
            magnitude_index !== '0 || frame_count !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL midrst_outputs got v=%b l=%b e=%b mag=%0d idx=%0d frames=%0d want all 0",
                     magnitude_valid, magnitude_last, index_error, magnitude_out, magnitude_index, frame_count);
        end
        idle(L + 6);
        vectors++;
        if (out_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL midrst_flushed got %0d beats want 0", out_q.size());
        end
        err_q.delete();
        drive(1'b1, 5, 12, 0, 1'b0, e);
        idle(L + 4);
        vectors++;
        if (out_q.size() != 1 || err_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL midrst_recover_count got beats=%0d errs=%0d want 1/0", out_q.size(), err_q.size());
        end else begin
            vectors++;
            if (out_q[0].cyc != e + L || out_q[0].mag !== M'(13)) begin
                miscompares++;
                $display("[TB] FAIL midrst_recover got cyc=%0d mag=%0d want cyc=%0d mag=13",
                         out_q[0].cyc, out_q[0].mag, e + L);
            end
        end
    endtask

    task automatic test_idle_zero();
        vectors++;
        if (stale_cnt != 0) begin
            miscompares++;
            $display("[TB] FAIL idle_zero got %0d nonzero idle magnitudes want 0", stale_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_single();
        test_corners();
        test_index_error();
        test_gaps();
        test_reset_midflight();
        test_idle_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
